// File: rtl/tm_l2_bank_router.sv
// Banked L2 timing-model front-end: routes demand/writeback requests into per-bank
// FIFOs and folds per-bank hit/miss/wb pulses into single-pulse-per-cycle backlogs.

package iu_pkg;
  typedef struct packed {
    logic clk;
  } iu_clk_type;
endpackage

module tm_l2_bank_router #(
  parameter int unsigned NUM_BANKS   = 8,
  parameter int unsigned LB          = $clog2(NUM_BANKS),
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned OFFSET_BITS = 6,
  parameter int unsigned TID_W       = 6,
  parameter int unsigned QDEPTH      = 4,
  parameter int unsigned CTR_W       = 8
) (
  input  iu_pkg::iu_clk_type            gclk,
  input  logic                          rst,
  input  logic                          run_reg,
  input  logic [LB:0]                   cfg_log2_banks,
  input  logic                          cfg_hash_en,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic                          req_is_wb,
  input  logic [TID_W-1:0]              req_tid,
  output logic [NUM_BANKS-1:0]          bank_valid,
  input  logic [NUM_BANKS-1:0]          bank_ready,
  output logic [NUM_BANKS*ADDR_W-1:0]   bank_addr,
  output logic [NUM_BANKS-1:0]          bank_is_wb,
  output logic [NUM_BANKS*TID_W-1:0]    bank_tid,
  input  logic [NUM_BANKS-1:0]          bank_hit,
  input  logic [NUM_BANKS-1:0]          bank_miss,
  input  logic [NUM_BANKS-1:0]          bank_wb,
  output logic                          agg_hit,
  output logic                          agg_miss,
  output logic                          agg_wb,
  output logic                          ctr_overflow,
  output logic                          stay_stalled
);

  localparam int unsigned QW = $clog2(QDEPTH);
  localparam int unsigned LW = ADDR_W - OFFSET_BITS;
  localparam int unsigned SW = CTR_W + LB + 1;
  localparam logic [LB:0]   LB_V = (LB + 1)'(LB);
  localparam logic [SW-1:0] CMAX = {{(LB + 1){1'b0}}, {CTR_W{1'b1}}};

  logic clk;
  assign clk = gclk.clk;

  // ---------------- configuration ----------------
  logic [LB:0] cur_log2;
  logic        cur_hash;
  logic        cfg_first;
  logic [LB:0] cfg_clamped;
  logic        all_empty;

  assign cfg_clamped = (cfg_log2_banks > LB_V) ? LB_V : cfg_log2_banks;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_log2  <= '0;
      cur_hash  <= 1'b0;
      cfg_first <= 1'b1;
    end else begin
      cfg_first <= 1'b0;
      if (cfg_first || (all_empty && !req_valid)) begin
        cur_log2 <= cfg_clamped;
        cur_hash <= cfg_hash_en;
      end
    end
  end

  // ---------------- bank select and local address ----------------
  logic [LB-1:0]     mask;
  logic [LB-1:0]     raw;
  logic [LB-1:0]     upper;
  logic [LB-1:0]     sel;
  logic [LW-1:0]     line;
  logic [ADDR_W-1:0] push_addr;

  always_comb begin
    mask      = ~({LB{1'b1}} << cur_log2);
    raw       = req_addr[OFFSET_BITS +: LB];
    upper     = req_addr[OFFSET_BITS + LB +: LB];
    sel       = (cur_hash ? (raw ^ upper) : raw) & mask;
    line      = req_addr[ADDR_W-1:OFFSET_BITS];
    push_addr = {line >> cur_log2, req_addr[OFFSET_BITS-1:0]};
  end

  // ---------------- per-bank FIFOs ----------------
  logic [ADDR_W-1:0] mem_addr [NUM_BANKS][QDEPTH];
  logic              mem_wb   [NUM_BANKS][QDEPTH];
  logic [TID_W-1:0]  mem_tid  [NUM_BANKS][QDEPTH];
  logic [QW:0]       wr_ptr   [NUM_BANKS];
  logic [QW:0]       rd_ptr   [NUM_BANKS];
  logic [NUM_BANKS-1:0] full;
  logic [NUM_BANKS-1:0] empty;
  logic [NUM_BANKS-1:0] push_vec;
  logic [NUM_BANKS-1:0] pop_vec;
  logic                 push;

  always_comb begin
    full  = '0;
    empty = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][QW] != rd_ptr[i][QW]) &&
                 (wr_ptr[i][QW-1:0] == rd_ptr[i][QW-1:0]);
    end
  end

  assign all_empty = &empty;
  // Ready follows the addressed FIFO only; a same-cycle pop does not free a slot.
  assign req_ready = !rst && !full[sel];
  assign push      = req_valid && req_ready;

  always_comb begin
    push_vec = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      push_vec[i] = push && (sel == LB'(i));
    end
  end

  assign bank_valid = ~empty & {NUM_BANKS{run_reg}};
  assign pop_vec    = bank_valid & bank_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        if (push_vec[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop_vec[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (push_vec[i]) begin
        mem_addr[i][wr_ptr[i][QW-1:0]] <= push_addr;
        mem_wb[i][wr_ptr[i][QW-1:0]]   <= req_is_wb;
        mem_tid[i][wr_ptr[i][QW-1:0]]  <= req_tid;
      end
    end
  end

  always_comb begin
    bank_addr  = '0;
    bank_is_wb = '0;
    bank_tid   = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      bank_addr[i*ADDR_W +: ADDR_W] = mem_addr[i][rd_ptr[i][QW-1:0]];
      bank_is_wb[i]                 = mem_wb[i][rd_ptr[i][QW-1:0]];
      bank_tid[i*TID_W +: TID_W]    = mem_tid[i][rd_ptr[i][QW-1:0]];
    end
  end

  // ---------------- event aggregation (0=hit, 1=miss, 2=wb) ----------------
  logic [NUM_BANKS-1:0] ev      [3];
  logic [CTR_W-1:0]     backlog [3];
  logic [LB:0]          pc      [3];
  logic [SW-1:0]        sum     [3];
  logic [2:0]           agg;
  logic [2:0]           sat;

  always_comb begin
    ev[0] = bank_hit;
    ev[1] = bank_miss;
    ev[2] = bank_wb;
    agg   = '0;
    sat   = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      pc[k] = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        pc[k] = pc[k] + (LB + 1)'(ev[k][b]);
      end
      agg[k] = (backlog[k] != '0);
      sum[k] = SW'(backlog[k]) - SW'(agg[k]) + SW'(pc[k]);
      sat[k] = (sum[k] > CMAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < 3; k++) backlog[k] <= '0;
      ctr_overflow <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        backlog[k] <= sat[k] ? {CTR_W{1'b1}} : sum[k][CTR_W-1:0];
      end
      if (|sat) ctr_overflow <= 1'b1;
    end
  end

  assign agg_hit      = agg[0];
  assign agg_miss     = agg[1];
  assign agg_wb       = agg[2];
  assign stay_stalled = !all_empty || (|agg);

endmodule

// File: tb/tb_tm_l2_bank_router.sv
// Directed bench for tm_l2_bank_router: routing, hashing, full FIFO, aggregation,
// deferred config reload and mid-operation reset.

module tb_tm_l2_bank_router;

  localparam int unsigned NB = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned TW = 6;

  logic clk = 1'b0;
  iu_pkg::iu_clk_type gclk;
  assign gclk.clk = clk;
  always #5 clk = ~clk;

  logic            rst;
  logic            run_reg;
  logic [3:0]      cfg_log2_banks;
  logic            cfg_hash_en;
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic            req_is_wb;
  logic [TW-1:0]   req_tid;
  logic [NB-1:0]   bank_valid;
  logic [NB-1:0]   bank_ready;
  logic [NB*AW-1:0] bank_addr;
  logic [NB-1:0]   bank_is_wb;
  logic [NB*TW-1:0] bank_tid;
  logic [NB-1:0]   bank_hit, bank_miss, bank_wb;
  logic            agg_hit, agg_miss, agg_wb;
  logic            ctr_overflow;
  logic            stay_stalled;

  tm_l2_bank_router #(
    .NUM_BANKS(8), .ADDR_W(32), .OFFSET_BITS(6), .TID_W(6), .QDEPTH(4), .CTR_W(8)
  ) dut (
    .gclk(gclk), .rst(rst), .run_reg(run_reg),
    .cfg_log2_banks(cfg_log2_banks), .cfg_hash_en(cfg_hash_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_is_wb(req_is_wb), .req_tid(req_tid),
    .bank_valid(bank_valid), .bank_ready(bank_ready), .bank_addr(bank_addr),
    .bank_is_wb(bank_is_wb), .bank_tid(bank_tid),
    .bank_hit(bank_hit), .bank_miss(bank_miss), .bank_wb(bank_wb),
    .agg_hit(agg_hit), .agg_miss(agg_miss), .agg_wb(agg_wb),
    .ctr_overflow(ctr_overflow), .stay_stalled(stay_stalled)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] baddr(input int unsigned b);
    return bank_addr[b*AW +: AW];
  endfunction

  function automatic logic [TW-1:0] btid(input int unsigned b);
    return bank_tid[b*TW +: TW];
  endfunction

  initial begin
    rst = 1'b1; run_reg = 1'b1; cfg_log2_banks = '0; cfg_hash_en = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_is_wb = 1'b0; req_tid = '0;
    bank_ready = '0; bank_hit = '0; bank_miss = '0; bank_wb = '0;
    tick; tick;

    check_eq("rst_bank_valid", bank_valid, 64'h0);
    check_eq("rst_req_ready", req_ready, 64'h0);
    check_eq("rst_agg_hit", agg_hit, 64'h0);
    check_eq("rst_agg_miss", agg_miss, 64'h0);
    check_eq("rst_agg_wb", agg_wb, 64'h0);
    check_eq("rst_ovf", ctr_overflow, 64'h0);
    check_eq("rst_stall", stay_stalled, 64'h0);

    // routing without hash, 4 active banks
    rst = 1'b0; cfg_log2_banks = 4'd2;
    tick;
    req_valid = 1'b1; req_addr = 32'h0000_00C0; req_tid = 6'd1; req_is_wb = 1'b1;
    #1 check_eq("t1_ready", req_ready, 64'h1);
    tick;
    req_valid = 1'b0; req_is_wb = 1'b0;
    #1;
    check_eq("t1_valid", bank_valid, 64'h08);
    check_eq("t1_addr3", baddr(3), 64'h0);
    check_eq("t1_is_wb", bank_is_wb[3], 64'h1);
    check_eq("t1_tid3", btid(3), 64'h1);
    check_eq("t1_stall", stay_stalled, 64'h1);
    bank_ready = '1;
    tick;
    bank_ready = '0;
    check_eq("t1_drained", bank_valid, 64'h0);

    // hashed select, 8 banks
    cfg_log2_banks = 4'd3; cfg_hash_en = 1'b1;
    tick;
    req_valid = 1'b1; req_addr = 32'h0000_0240; req_tid = 6'd2;
    tick;
    req_valid = 1'b0;
    #1;
    check_eq("t2_hash_valid", bank_valid, 64'h01);
    check_eq("t2_hash_addr0", baddr(0), 64'h40);
    bank_ready = '1;
    tick;
    bank_ready = '0; cfg_hash_en = 1'b0;
    tick;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    #1;
    check_eq("t2_nohash_valid", bank_valid, 64'h02);
    check_eq("t2_nohash_addr1", baddr(1), 64'h40);
    bank_ready = '1;
    tick;
    bank_ready = '0;

    // full FIFO on bank 0, order preserved
    req_valid = 1'b1; req_addr = '0;
    for (int k = 1; k <= 4; k++) begin
      req_tid = 6'(k);
      #1 check_eq("t3_fill_ready", req_ready, 64'h1);
      tick;
    end
    req_tid = 6'd5;
    #1;
    check_eq("t3_full_ready", req_ready, 64'h0);
    check_eq("t3_full_valid", bank_valid, 64'h01);
    tick;
    bank_ready = 8'h01;
    #1;
    check_eq("t3_pop_cycle_ready", req_ready, 64'h0);
    check_eq("t3_head_tid", btid(0), 64'h1);
    tick;
    bank_ready = '0;
    #1 check_eq("t3_after_pop_ready", req_ready, 64'h1);
    tick;
    req_valid = 1'b0; bank_ready = 8'h01;
    for (int j = 2; j <= 5; j++) begin
      #1 check_eq("t3_order_tid", btid(0), 64'(j));
      tick;
    end
    bank_ready = '0;
    #1 check_eq("t3_empty", bank_valid, 64'h0);

    // aggregation of 8 simultaneous hits
    bank_hit = 8'hFF;
    tick;
    bank_hit = '0;
    check_eq("t4_miss_idle", agg_miss, 64'h0);
    for (int k = 0; k < 8; k++) begin
      check_eq("t4_agg_hit_on", agg_hit, 64'h1);
      tick;
    end
    check_eq("t4_agg_hit_off", agg_hit, 64'h0);
    bank_miss = 8'h05; bank_wb = 8'h80;
    tick;
    bank_miss = '0; bank_wb = '0;
    check_eq("t4_miss_1", agg_miss, 64'h1);
    check_eq("t4_wb_1", agg_wb, 64'h1);
    check_eq("t4_stall_evt", stay_stalled, 64'h1);
    tick;
    check_eq("t4_miss_2", agg_miss, 64'h1);
    check_eq("t4_wb_2", agg_wb, 64'h0);
    tick;
    check_eq("t4_miss_3", agg_miss, 64'h0);
    check_eq("t4_stall_idle", stay_stalled, 64'h0);
    check_eq("t4_ovf_before", ctr_overflow, 64'h0);
    bank_hit = 8'hFF;
    repeat (40) tick;
    bank_hit = '0;
    check_eq("t4_ovf_set", ctr_overflow, 64'h1);
    repeat (5) tick;
    check_eq("t4_ovf_sticky", ctr_overflow, 64'h1);
    check_eq("t4_agg_hit_backlog", agg_hit, 64'h1);

    // config change deferred while busy
    cfg_log2_banks = 4'd2;
    tick;
    req_valid = 1'b1; req_addr = '0; req_tid = 6'd1;
    tick;
    req_tid = 6'd2;
    tick;
    req_valid = 1'b0; cfg_log2_banks = 4'd1;
    tick; tick;
    req_valid = 1'b1; req_addr = 32'h0000_01C0; req_tid = 6'd3;
    tick;
    req_valid = 1'b0;
    #1;
    check_eq("t5_old_cfg_valid", bank_valid, 64'h09);
    check_eq("t5_old_cfg_addr3", baddr(3), 64'h40);
    bank_ready = '1;
    tick; tick;
    bank_ready = '0;
    check_eq("t5_drained", bank_valid, 64'h0);
    tick;
    req_valid = 1'b1; req_tid = 6'd4;
    tick;
    req_valid = 1'b0;
    #1;
    check_eq("t5_new_cfg_valid", bank_valid, 64'h02);
    check_eq("t5_new_cfg_addr1", baddr(1), 64'hC0);
    bank_ready = '1;
    tick;
    bank_ready = '0;

    // run_reg gating, then reset with queued work and pending events
    run_reg = 1'b0;
    req_valid = 1'b1; req_addr = '0; req_tid = 6'd7;
    tick;
    req_valid = 1'b0;
    #1 check_eq("t6_run_off_valid", bank_valid, 64'h0);
    run_reg = 1'b1;
    #1 check_eq("t6_run_on_valid", bank_valid, 64'h01);
    req_valid = 1'b1; bank_hit = 8'h1F;
    tick;
    bank_hit = '0;
    tick;
    req_valid = 1'b0;
    #1;
    check_eq("t6_pre_stall", stay_stalled, 64'h1);
    check_eq("t6_pre_ovf", ctr_overflow, 64'h1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    check_eq("t6_valid", bank_valid, 64'h0);
    check_eq("t6_agg_hit", agg_hit, 64'h0);
    check_eq("t6_agg_miss", agg_miss, 64'h0);
    check_eq("t6_agg_wb", agg_wb, 64'h0);
    check_eq("t6_stall", stay_stalled, 64'h0);
    check_eq("t6_ovf", ctr_overflow, 64'h0);
    check_eq("t6_ready", req_ready, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
